ram_sc_be_ctrl: RTL and testbench
=================================

// Module: ram_sc_be_ctrl
// PURPOSE
// - Sequencer/arbiter for one single-clock byte-enable block RAM: 1 write port, 1 read port, 1-cycle read latency.
// - After reset, zero-fills every row. Then shares the RAM write port between two requesters (A, B) by round-robin.
// - Gives one read requester a valid/ready request channel and a 1-cycle response channel.
// - Sits between client logic and the RAM instance; drives all RAM ports.
// PARAMETERS
// - ADDR_NBITS  5  row address width; 2**ADDR_NBITS rows
// - SPAN_NBITS  8  bits per byte-enable span
// - NUM_SPANS   8  spans per row; mask width
// PORTS (W = NUM_SPANS*SPAN_NBITS)
// - clk_in            in   1           clock; all logic on the rising edge
// - reset_in          in   1           synchronous, active-high reset
// - initDone_out      out  1           high once the zero-fill sweep has completed
// - aValid_in         in   1           write request A valid
// - aReady_out        out  1           write request A accepted this cycle
// - aAddr_in          in   ADDR_NBITS  write address A
// - aMask_in          in   NUM_SPANS   span enables A
// - aData_in          in   W           write data A
// - bValid_in / bReady_out / bAddr_in / bMask_in / bData_in   as A, for requester B
// - rdValid_in        in   1           read request valid
// - rdReady_out       out  1           read request accepted this cycle
// - rdAddr_in         in   ADDR_NBITS  read address
// - rspValid_out      out  1           read response valid; no backpressure
// - rspData_out       out  W           read response data
// - ramWrMask_out     out  NUM_SPANS   to RAM wrMask
// - ramWrAddr_out     out  ADDR_NBITS  to RAM wrAddr
// - ramWrData_out     out  W           to RAM wrData
// - ramRdAddr_out     out  ADDR_NBITS  to RAM rdAddr
// - ramRdData_in      in   W           from RAM rdData, registered inside RAM
// BEHAVIOUR
// - FSM states: S_INIT, S_RUN. Reset forces S_INIT, initAddr=0, lastGrant=B (so A wins first tie), rspValid_out=0, initDone_out=0.
// - S_INIT, every cycle:
//   - ramWrMask_out = all ones; ramWrAddr_out = initAddr; ramWrData_out = 0.
//   - initAddr increments; on initAddr = 2**ADDR_NBITS-1, go to S_RUN and set initDone_out=1.
//   - Sweep takes exactly 2**ADDR_NBITS cycles.
//   - aReady_out, bReady_out and rdReady_out are 0 throughout.
// - S_RUN write arbitration, combinational:
//   - Only A valid: grant A. Only B valid: grant B.
//   - Both valid: grant the one that is not lastGrant.
//   - Granted port's Ready=1; the other port's Ready=0.
//   - Grant drives ramWrMask/Addr/Data from that requester. lastGrant updates on grant.
//   - No grant: ramWrMask_out = 0; addr/data are don't-care but held stable.
// - Fairness: with both held valid, grants alternate A,B,A,B. Neither requester waits more than 1 cycle.
// - Mask passthrough: a granted request with mask 0 is accepted and writes nothing.
// - Read channel:
//   - In S_RUN, rdReady_out=1 always.
//   - On accept, ramRdAddr_out = rdAddr_in (combinational). rspValid_out=1 on the next cycle, with rspData_out = ramRdData_in.
//   - Throughput is 1 read per cycle. rspValid_out is a registered copy of (rdValid_in & rdReady_out).
// - Same-cycle read and write to the same row: the read returns the pre-write contents (RAM read-before-write).
//   - A read issued on the following cycle returns the new contents.
// - Ready ports are combinational from valid inputs and state only. Valid must not depend on Ready.
// - Reset mid-sweep or mid-run:
//   - Next cycle is S_INIT, initAddr=0, and the sweep restarts.
//   - Any in-flight read response is dropped (rspValid_out=0).
// CONFIGURATION
// - RAM_SC_BE_CTRL_STATS_EN defined: adds outputs aGrants_out[15:0] and bGrants_out[15:0].
//   - Each is a saturating count of accepted writes per requester (saturates at 0xFFFF).
//   - Cleared by reset_in. Not incremented during S_INIT.
// - Macro undefined: neither port nor counter exists; behaviour otherwise identical.
// TESTING
// - Reset 1 cycle, ADDR_NBITS=5 -> initDone_out rises 32 cycles after reset drops; all readies 0 before that; every row reads 0.
// - After init: A writes addr 3, mask 0x01, data 0x..AB -> read addr 3 gives rspData_out=0x00000000000000AB one cycle after accept.
// - aValid_in & bValid_in held high 6 cycles -> grant order A,B,A,B,A,B; ramWrMask_out never 0 in that window.
// - Same cycle: write addr 7 = 0x1122334455667788 and read addr 7 -> response = 0; read again next cycle -> 0x1122334455667788.
// - Assert reset_in at sweep cycle 10 -> initAddr restarts at 0; initDone_out rises 32 cycles after release; pending rspValid_out cleared.
// - STATS_EN: 70000 back-to-back A-only writes -> aGrants_out=0xFFFF, bGrants_out=0.

Source files
------------

// File: rtl/ram_sc_be_ctrl.sv
// ram_sc_be_ctrl
// Sequencer and arbiter for one single-clock byte-enable block RAM that has
// one write port, one read port and a 1-cycle registered read.
//  - After reset it zero-fills every row, one row per cycle.
//  - It then shares the RAM write port between requesters A and B by round-robin.
//  - It gives one read requester a valid/ready request channel and a
//    1-cycle response channel.
//
// Ports (W = NUM_SPANS*SPAN_NBITS)
//   clk_in, reset_in            clock and synchronous active-high reset
//   initDone_out                high once the zero-fill sweep has completed
//   aValid_in/aReady_out/aAddr_in/aMask_in/aData_in   write requester A
//   bValid_in/bReady_out/bAddr_in/bMask_in/bData_in   write requester B
//   rdValid_in/rdReady_out/rdAddr_in                  read request channel
//   rspValid_out/rspData_out                          read response, no backpressure
//   ramWrMask_out/ramWrAddr_out/ramWrData_out         RAM write port
//   ramRdAddr_out/ramRdData_in                        RAM read port
//
// Optional feature, macro RAM_SC_BE_CTRL_STATS_EN:
//   aGrants_out, bGrants_out    saturating 16-bit counts of accepted writes

module ram_sc_be_ctrl #(
    parameter int ADDR_NBITS = 5,
    parameter int SPAN_NBITS = 8,
    parameter int NUM_SPANS  = 8
) (
    input  logic                            clk_in,
    input  logic                            reset_in,
    output logic                            initDone_out,
    input  logic                            aValid_in,
    output logic                            aReady_out,
    input  logic [ADDR_NBITS-1:0]           aAddr_in,
    input  logic [NUM_SPANS-1:0]            aMask_in,
    input  logic [NUM_SPANS*SPAN_NBITS-1:0] aData_in,
    input  logic                            bValid_in,
    output logic                            bReady_out,
    input  logic [ADDR_NBITS-1:0]           bAddr_in,
    input  logic [NUM_SPANS-1:0]            bMask_in,
    input  logic [NUM_SPANS*SPAN_NBITS-1:0] bData_in,
    input  logic                            rdValid_in,
    output logic                            rdReady_out,
    input  logic [ADDR_NBITS-1:0]           rdAddr_in,
    output logic                            rspValid_out,
    output logic [NUM_SPANS*SPAN_NBITS-1:0] rspData_out,
    output logic [NUM_SPANS-1:0]            ramWrMask_out,
    output logic [ADDR_NBITS-1:0]           ramWrAddr_out,
    output logic [NUM_SPANS*SPAN_NBITS-1:0] ramWrData_out,
    output logic [ADDR_NBITS-1:0]           ramRdAddr_out,
    input  logic [NUM_SPANS*SPAN_NBITS-1:0] ramRdData_in
`ifdef RAM_SC_BE_CTRL_STATS_EN
    ,
    output logic [15:0]                     aGrants_out,
    output logic [15:0]                     bGrants_out
`endif
);

    localparam int W = NUM_SPANS * SPAN_NBITS;
    localparam logic [ADDR_NBITS-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_NBITS-1:0] ONE_ADDR  = {{(ADDR_NBITS-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_NBITS-1:0] initAddr_q, initAddr_d;
    // 1 means B was granted last, so A wins the next tie.
    logic                  lastGrantB_q, lastGrantB_d;
    logic                  rspValid_q;
    // Last values driven onto the write port, replayed while nobody is granted
    // so the RAM address/data pins do not toggle needlessly.
    logic [ADDR_NBITS-1:0] holdAddr_q, holdAddr_d;
    logic [W-1:0]          holdData_q, holdData_d;
    logic                  grantA;
    logic                  grantB;

    // State, sweep pointer, arbitration history and held write-port values.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= S_INIT;
            initAddr_q   <= '0;
            lastGrantB_q <= 1'b1;
            holdAddr_q   <= '0;
            holdData_q   <= '0;
        end else begin
            state_q      <= state_d;
            initAddr_q   <= initAddr_d;
            lastGrantB_q <= lastGrantB_d;
            holdAddr_q   <= holdAddr_d;
            holdData_q   <= holdData_d;
        end
    end

    // Next-state logic, write arbitration and RAM write-port mux.
    always_comb begin
        state_d       = state_q;
        initAddr_d    = initAddr_q;
        lastGrantB_d  = lastGrantB_q;
        grantA        = 1'b0;
        grantB        = 1'b0;
        rdReady_out   = 1'b0;
        ramWrMask_out = '0;
        ramWrAddr_out = holdAddr_q;
        ramWrData_out = holdData_q;

        unique case (state_q)
            S_INIT: begin
                ramWrMask_out = '1;
                ramWrAddr_out = initAddr_q;
                ramWrData_out = '0;
                // The pointer wraps back to 0 on the last row, leaving it
                // ready for a later sweep.
                initAddr_d    = initAddr_q + ONE_ADDR;
                if (initAddr_q == LAST_ADDR) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rdReady_out = 1'b1;
                // On a tie, the requester that was not granted last wins.
                if (aValid_in && (!bValid_in || lastGrantB_q)) begin
                    grantA = 1'b1;
                end else if (bValid_in) begin
                    grantB = 1'b1;
                end

                if (grantA) begin
                    ramWrMask_out = aMask_in;
                    ramWrAddr_out = aAddr_in;
                    ramWrData_out = aData_in;
                    lastGrantB_d  = 1'b0;
                end else if (grantB) begin
                    ramWrMask_out = bMask_in;
                    ramWrAddr_out = bAddr_in;
                    ramWrData_out = bData_in;
                    lastGrantB_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        holdAddr_d = ramWrAddr_out;
        holdData_d = ramWrData_out;
    end

    // The response flag tracks an accepted read by one cycle, matching the
    // RAM's registered read. Reset drops any response still in flight.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            rspValid_q <= 1'b0;
        end else begin
            rspValid_q <= rdValid_in & rdReady_out;
        end
    end

    assign initDone_out  = (state_q == S_RUN);
    assign aReady_out    = grantA;
    assign bReady_out    = grantB;
    assign ramRdAddr_out = rdAddr_in;
    assign rspValid_out  = rspValid_q;
    assign rspData_out   = ramRdData_in;

`ifdef RAM_SC_BE_CTRL_STATS_EN
    logic [15:0] aGrants_q;
    logic [15:0] bGrants_q;

    // Saturating per-requester counts of accepted writes. Grants never occur
    // during the sweep, so these counts cannot advance in S_INIT.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            aGrants_q <= '0;
            bGrants_q <= '0;
        end else begin
            if (grantA && (aGrants_q != 16'hFFFF)) begin
                aGrants_q <= aGrants_q + 16'd1;
            end
            if (grantB && (bGrants_q != 16'hFFFF)) begin
                bGrants_q <= bGrants_q + 16'd1;
            end
        end
    end

    assign aGrants_out = aGrants_q;
    assign bGrants_out = bGrants_q;
`endif

endmodule

// File: tb/tb_ram_sc_be_ctrl.sv
// tb_ram_sc_be_ctrl
// Directed self-checking bench for ram_sc_be_ctrl with ADDR_NBITS=5, 8x8-bit spans.
// It contains a behavioural byte-enable RAM with the following properties:
//  - read-before-write
//  - registered read data
//  - rows that start out undefined, so that the zero-fill sweep is exercised
// Macro RAM_SC_BE_CTRL_STATS_EN, when defined, also checks the grant counters.

module tb_ram_sc_be_ctrl;

    localparam int AW = 5;
    localparam int NS = 8;
    localparam int DW = 64;

    localparam logic [DW-1:0] A_WORD = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [DW-1:0] B_WORD = 64'hBBBB_BBBB_BBBB_BBBB;

    logic          clk;
    logic          reset;
    logic          initDone;
    logic          aValid, aReady, bValid, bReady;
    logic [AW-1:0] aAddr, bAddr;
    logic [NS-1:0] aMask, bMask;
    logic [DW-1:0] aData, bData;
    logic          rdValid, rdReady;
    logic [AW-1:0] rdAddr;
    logic          rspValid;
    logic [DW-1:0] rspData;
    logic [NS-1:0] ramWrMask;
    logic [AW-1:0] ramWrAddr;
    logic [DW-1:0] ramWrData;
    logic [AW-1:0] ramRdAddr;
    logic [DW-1:0] ramRdData;
`ifdef RAM_SC_BE_CTRL_STATS_EN
    logic [15:0]   aGrants, bGrants;
`endif

    int checkCount = 0;
    int passCount  = 0;

    ram_sc_be_ctrl #(.ADDR_NBITS(AW), .SPAN_NBITS(8), .NUM_SPANS(NS)) dut (
        .clk_in        (clk),
        .reset_in      (reset),
        .initDone_out  (initDone),
        .aValid_in     (aValid),
        .aReady_out    (aReady),
        .aAddr_in      (aAddr),
        .aMask_in      (aMask),
        .aData_in      (aData),
        .bValid_in     (bValid),
        .bReady_out    (bReady),
        .bAddr_in      (bAddr),
        .bMask_in      (bMask),
        .bData_in      (bData),
        .rdValid_in    (rdValid),
        .rdReady_out   (rdReady),
        .rdAddr_in     (rdAddr),
        .rspValid_out  (rspValid),
        .rspData_out   (rspData),
        .ramWrMask_out (ramWrMask),
        .ramWrAddr_out (ramWrAddr),
        .ramWrData_out (ramWrData),
        .ramRdAddr_out (ramRdAddr),
        .ramRdData_in  (ramRdData)
`ifdef RAM_SC_BE_CTRL_STATS_EN
        ,
        .aGrants_out   (aGrants),
        .bGrants_out   (bGrants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: nonblocking writes make a same-cycle read see old data.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        ramRdData <= mem[ramRdAddr];
        for (int b = 0; b < NS; b++) begin
            if (ramWrMask[b]) mem[ramWrAddr][b*8 +: 8] <= ramWrData[b*8 +: 8];
        end
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Applies one cycle of inputs just after a rising edge and returns at the
    // following falling edge, where outputs are sampled.
    task automatic applyStimulus(
        input logic rst,
        input logic aV, input logic [AW-1:0] aA, input logic [NS-1:0] aM, input logic [DW-1:0] aD,
        input logic bV, input logic [AW-1:0] bA, input logic [NS-1:0] bM, input logic [DW-1:0] bD,
        input logic rV, input logic [AW-1:0] rA);
        @(posedge clk);
        #1;
        reset   = rst;
        aValid  = aV; aAddr = aA; aMask = aM; aData = aD;
        bValid  = bV; bAddr = bA; bMask = bM; bData = bD;
        rdValid = rV; rdAddr = rA;
        @(negedge clk);
    endtask

    task automatic idleCycle(input logic rst);
        applyStimulus(rst, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic readCycle(input logic [AW-1:0] addr);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1, addr);
    endtask

    // Full 32-row sweep with every requester valid: readies must stay low
    // while the write port walks the rows with full mask and zero data.
    task automatic sweepCheck();
        for (int i = 0; i < (1 << AW); i++) begin
            applyStimulus(1'b0, 1'b1, 5'd1, 8'hFF, A_WORD, 1'b1, 5'd2, 8'hFF, B_WORD,
                          1'b1, 5'd0);
            checkOutput("sweep_flags", {60'd0, initDone, aReady, bReady, rdReady}, '0);
            checkOutput("sweep_addr", {59'd0, ramWrAddr}, {59'd0, 5'(i)});
            checkOutput("sweep_wr", {ramWrMask, ramWrData[55:0]}, {8'hFF, 56'd0});
        end
    endtask

    initial begin
        logic [DW-1:0] expRow;
        logic          expA;

        reset = 1'b1;
        aValid = 0; aAddr = 0; aMask = 0; aData = 0;
        bValid = 0; bAddr = 0; bMask = 0; bData = 0;
        rdValid = 0; rdAddr = 0;

        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("reset_initDone", {63'd0, initDone}, '0);
        checkOutput("reset_rspValid", {63'd0, rspValid}, '0);

        sweepCheck();

        // Both requesters held valid: A wins the first tie, then strict alternation.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b1, 5'd20, 8'hFF, A_WORD, 1'b1, 5'd21, 8'hFF, B_WORD,
                          1'b0, '0);
            expA = (k % 2 == 0);
            if (k == 0) checkOutput("initDone_rise", {63'd0, initDone}, 64'd1);
            checkOutput("fair_ready", {62'd0, aReady, bReady}, {62'd0, expA, !expA});
            checkOutput("fair_mask", {56'd0, ramWrMask}, 64'h00FF);
            checkOutput("fair_addr", {59'd0, ramWrAddr}, expA ? 64'd20 : 64'd21);
        end

        // Read every row back; only rows 20 and 21 were written.
        for (int k = 0; k <= (1 << AW); k++) begin
            if (k < (1 << AW)) readCycle(5'(k));
            else               idleCycle(1'b0);
            if (k > 0) begin
                expRow = (k - 1 == 20) ? A_WORD : (k - 1 == 21) ? B_WORD : 64'd0;
                checkOutput("readall_valid", {63'd0, rspValid}, 64'd1);
                checkOutput("readall_data", rspData, expRow);
            end
        end

        // Single-span write from A to row 3.
        applyStimulus(1'b0, 1'b1, 5'd3, 8'h01, 64'h1234_5678_9ABC_DEAB, 1'b0, '0, '0, '0,
                      1'b0, '0);
        checkOutput("a_only_ready", {62'd0, aReady, bReady}, 64'b10);
        checkOutput("a_only_port", {51'd0, ramWrMask, ramWrAddr}, {51'd0, 8'h01, 5'd3});
        checkOutput("rsp_idle", {63'd0, rspValid}, '0);
        readCycle(5'd3);
        checkOutput("nogrant_mask", {55'd0, aReady, ramWrMask}, '0);
        idleCycle(1'b0);
        checkOutput("row3_valid", {63'd0, rspValid}, 64'd1);
        checkOutput("row3_data", rspData, 64'h0000_0000_0000_00AB);

        // B merges the top span into row 3; A sends a mask-0 write to row 4.
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 5'd3, 8'h80, 64'hCD00_0000_0000_0000,
                      1'b0, '0);
        checkOutput("b_only_ready", {62'd0, aReady, bReady}, 64'b01);
        applyStimulus(1'b0, 1'b1, 5'd4, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, '0, '0,
                      1'b0, '0);
        checkOutput("mask0_ready", {63'd0, aReady}, 64'd1);
        checkOutput("mask0_mask", {56'd0, ramWrMask}, '0);
        readCycle(5'd3);
        readCycle(5'd4);
        checkOutput("row3_merge", rspData, 64'hCD00_0000_0000_00AB);
        idleCycle(1'b0);
        checkOutput("row4_untouched", rspData, 64'd0);

        // Same-cycle write and read of row 7, then a follow-up read.
        applyStimulus(1'b0, 1'b1, 5'd7, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, '0, '0, '0,
                      1'b1, 5'd7);
        readCycle(5'd7);
        checkOutput("rbw_old", {rspValid, rspData[62:0]}, {1'b1, 63'd0});
        idleCycle(1'b0);
        checkOutput("rbw_new", rspData, 64'h1122_3344_5566_7788);

        // Reset in the same cycle a read is accepted: the response is dropped.
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1, 5'd7);
        checkOutput("rst_rdReady", {63'd0, rdReady}, 64'd1);
        idleCycle(1'b0);
        checkOutput("rst_drop", {62'd0, rspValid, initDone}, '0);
        checkOutput("rst_restart", {56'd0, ramWrMask}, 64'h00FF);
        checkOutput("rst_addr0", {59'd0, ramWrAddr}, '0);
        for (int i = 1; i < 10; i++) idleCycle(1'b0);
        // Reset again at sweep row 10; the sweep must restart from row 0.
        idleCycle(1'b1);
        checkOutput("sweep10_addr", {59'd0, ramWrAddr}, 64'd10);
        sweepCheck();
        readCycle(5'd7);
        checkOutput("resweep_done", {63'd0, initDone}, 64'd1);
        idleCycle(1'b0);
        checkOutput("row7_rezeroed", {rspValid, rspData[62:0]}, {1'b1, 63'd0});

`ifdef RAM_SC_BE_CTRL_STATS_EN
        checkOutput("stats_clear", {32'd0, aGrants, bGrants}, '0);
        for (int n = 0; n < 70000; n++) begin
            applyStimulus(1'b0, 1'b1, 5'(n), 8'hFF, 64'(n), 1'b0, '0, '0, '0, 1'b0, '0);
        end
        checkOutput("stats_a_sat", {48'd0, aGrants}, 64'hFFFF);
        checkOutput("stats_b_zero", {48'd0, bGrants}, '0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
